cbi980_audio_buf: RTL and testbench
===================================

CBI980_AUDIO_BUF -- requirements
Module: cbi980_audio_buf

Interface
REQ-001 SHALL have parameter NCH, default 2: number of audio channels, legal range 1..8.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4: log2 of the per-FIFO depth, legal range 2..7.
REQ-003 SHALL have parameter SW, default 24: sample width, legal range 8..32.
REQ-004 SHALL have port clk  in  1  as the only clock.
REQ-005 SHALL have port rst  in  1  as reset; reset is synchronous and active-high.
REQ-006 SHALL have port interrupt  out  1  as the registered interrupt request.
REQ-007 SHALL have ports wr_addr  in  5, wr_data  in  32, wr_en  in  1 and wr_err  out  1 as the register write port.
REQ-008 SHALL have ports rd_addr  in  5, rd_data  out  32, rd_valid_in  in  1 and rd_valid_out  out  1 as the register read port.
REQ-009 SHALL have ports aud_in_vld  in  NCH and aud_in  in  NCH*SW, which carry codec samples into the RX FIFOs.
REQ-010 SHALL have ports aud_out_req  in  NCH and aud_out  out  NCH*SW, which carry samples from the TX FIFOs to the codec.

Function
REQ-011 Each channel SHALL own one RX FIFO and one TX FIFO of 2**DEPTH_LOG2 entries, SW bits wide, each with a level counter of DEPTH_LOG2+1 bits.
REQ-012 Register map SHALL be:
- 0 ID: read-only, returns 32'hcb199810.
- 1 SR: read-only status.
- 2 CR: control.
- 3 WMR: watermarks, rx_wm[7:0] and tx_wm[15:8].
- 4 STKR: sticky error flags.
- 16+ch: channel data register for channel ch.
REQ-013 SR bit ch SHALL be rxne; bit 8+ch SHALL be rx_hi (RX level >= rx_wm); bit 16+ch SHALL be tx_lo (TX level <= tx_wm); bit 24+ch SHALL be txnf.
REQ-014 CR bit ch SHALL be rxen; bit 8+ch SHALL be txen; bit 16 SHALL be ie_rx_hi; bit 17 SHALL be ie_tx_lo; bit 18 SHALL be ie_err; bit 31 SHALL be soft_rst, which self-clears and reads as 0.
REQ-015 STKR bit ch SHALL be rx_ovf and bit 8+ch SHALL be tx_unf; writing 1 to a bit SHALL clear it, and writing 0 SHALL leave it unchanged.
REQ-016 A read SHALL return rd_data and raise rd_valid_out exactly one cycle after rd_valid_in; rd_data SHALL hold its last value while no read is in progress.
REQ-017 A read of 16+ch SHALL return the RX head sample sign-extended to 32 bits and pop it; reading an empty RX FIFO SHALL return 0 and leave the pointers unchanged.
REQ-018 A write to 16+ch SHALL push wr_data[SW-1:0] into the TX FIFO; a write to a full TX FIFO SHALL be dropped and assert wr_err.
REQ-019 wr_err SHALL be combinational and assert when wr_en is high and any of the following holds: the address is 0 or 1, the address is 5..15, the address is 16+NCH or above, or the target TX FIFO is full.
REQ-020 Reads of unmapped addresses SHALL return 0 with no side effects.
REQ-021 aud_in_vld[ch] with rxen[ch] set SHALL push the sample; if the RX FIFO is full and not popped in the same cycle, the sample SHALL be dropped and rx_ovf[ch] set.
REQ-022 aud_out_req[ch] with txen[ch] set SHALL load aud_out[ch] from the TX head one cycle later and pop it; if the TX FIFO is empty, aud_out[ch] SHALL load 0 and tx_unf[ch] SHALL be set.
REQ-023 aud_in_vld and aud_out_req SHALL be ignored for a channel whose enable bit is 0; the FIFO and its flags SHALL stay unchanged.
REQ-024 A simultaneous push and pop on the same FIFO SHALL both take effect, leaving the level unchanged; this holds even when the FIFO is full, and the push is then not an overflow.
REQ-025 Pointers SHALL wrap modulo depth; full SHALL be level == 2**DEPTH_LOG2 and empty SHALL be level == 0.
REQ-026 interrupt SHALL be registered and equal to OR(ie_rx_hi & |rx_hi, ie_tx_lo & |tx_lo, ie_err & |STKR), giving one cycle of latency from a flag change.
REQ-027 A same-cycle hardware error event SHALL take priority over a W1C clear of the same STKR bit.

Reset
REQ-028 rst, or the cycle after soft_rst is written, SHALL empty all FIFOs and clear CR, STKR, rd_valid_out, interrupt, rd_data and aud_out to 0.
REQ-029 Reset SHALL load WMR with rx_wm = tx_wm = 2**(DEPTH_LOG2-1).
REQ-030 Reset SHALL abort any in-flight read: rd_valid_out SHALL be 0 on the cycle after reset.

Verification
REQ-031 (defaults) Set rxen0, push 3 samples 24'h800001, 1, 2, then read addr 16 three times -> returns 32'hff800001, 1, 2; a fourth read returns 0 and rxne0 = 0.
REQ-032 (depth 16) Push 17 RX samples on channel 1 with no reads -> level 16, rx_ovf1 = 1; with ie_err set, interrupt rises one cycle after the 17th push.
REQ-033 Set txen0, write 2 samples, issue 3 aud_out_req pulses -> aud_out0 shows the two samples then 0, and tx_unf0 = 1; writing STKR = 32'h100 clears tx_unf0.
REQ-034 Fill TX0 to 16 entries, then write once more -> wr_err = 1 and the level stays 16; a write to addr 1 or addr 18 (NCH=2) also gives wr_err = 1.
REQ-035 RX0 full, aud_in_vld and read of addr 16 in the same cycle -> no overflow, level stays 16; then write CR bit31 -> all levels 0 and WMR = 8/8.

Source files
------------

// File: rtl/cbi980_audio_buf.sv
// Multi-channel audio sample buffer: per-channel RX/TX FIFOs behind a small register file,
// with watermark status, sticky under/overflow flags and a registered interrupt.
module cbi980_audio_buf #(
  parameter int NCH        = 2,
  parameter int DEPTH_LOG2 = 4,
  parameter int SW         = 24
) (
  input  logic              clk,
  input  logic              rst,
  output logic              interrupt,
  input  logic [4:0]        wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              wr_en,
  output logic              wr_err,
  input  logic [4:0]        rd_addr,
  output logic [31:0]       rd_data,
  input  logic              rd_valid_in,
  output logic              rd_valid_out,
  input  logic [NCH-1:0]    aud_in_vld,
  input  logic [NCH*SW-1:0] aud_in,
  input  logic [NCH-1:0]    aud_out_req,
  output logic [NCH*SW-1:0] aud_out
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [4:0] ADDR_END = 5'(16 + NCH);
  localparam logic [7:0] WM_RST = 8'(DEPTH / 2);
  localparam logic [31:0] ID_VAL = 32'hcb199810;

  logic [SW-1:0] rx_mem [NCH][DEPTH];
  logic [SW-1:0] tx_mem [NCH][DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wp [NCH];
  logic [DEPTH_LOG2-1:0] rx_rp [NCH];
  logic [DEPTH_LOG2-1:0] tx_wp [NCH];
  logic [DEPTH_LOG2-1:0] tx_rp [NCH];
  logic [LW-1:0] rx_lvl [NCH];
  logic [LW-1:0] tx_lvl [NCH];
  logic [SW-1:0] aud_out_q [NCH];

  logic [31:0] cr;
  logic [15:0] wmr;
  logic [31:0] stkr;

  logic [NCH-1:0] rx_full, tx_full, rx_push, rx_pop, rx_ovf_set;
  logic [NCH-1:0] tx_req, tx_push, tx_pop, tx_unf_set, tx_drop, rx_hi, tx_lo;
  logic [31:0] sr, cr_mask, stkr_mask, stkr_set, stkr_clr, rd_mux;
  logic wr_cr, clr;

  assign wr_cr = wr_en && (wr_addr == 5'd2);
  // soft_rst is never stored; it acts exactly like rst on the following edge
  assign clr = rst || (wr_cr && wr_data[31]);
  assign stkr_clr = (wr_en && wr_addr == 5'd4) ? (wr_data & stkr_mask) : '0;

  always_comb begin
    rx_full = '0; tx_full = '0; rx_push = '0; rx_pop = '0; rx_ovf_set = '0;
    tx_req = '0; tx_push = '0; tx_pop = '0; tx_unf_set = '0; tx_drop = '0;
    rx_hi = '0; tx_lo = '0; sr = '0; stkr_set = '0; stkr_mask = '0;
    cr_mask = 32'h0007_0000;
    for (int ch = 0; ch < NCH; ch++) begin
      rx_full[ch] = (rx_lvl[ch] == FULL_LVL);
      tx_full[ch] = (tx_lvl[ch] == FULL_LVL);
      rx_pop[ch] = rd_valid_in && (rd_addr == 5'(16 + ch)) && (rx_lvl[ch] != '0);
      // a pop in the same cycle frees the slot, so a push into a full FIFO is legal then
      rx_push[ch] = aud_in_vld[ch] && cr[ch] && (!rx_full[ch] || rx_pop[ch]);
      rx_ovf_set[ch] = aud_in_vld[ch] && cr[ch] && rx_full[ch] && !rx_pop[ch];
      tx_req[ch] = aud_out_req[ch] && cr[8+ch];
      tx_pop[ch] = tx_req[ch] && (tx_lvl[ch] != '0);
      tx_unf_set[ch] = tx_req[ch] && (tx_lvl[ch] == '0);
      tx_push[ch] = wr_en && (wr_addr == 5'(16 + ch)) && (!tx_full[ch] || tx_pop[ch]);
      tx_drop[ch] = wr_en && (wr_addr == 5'(16 + ch)) && tx_full[ch] && !tx_pop[ch];
      rx_hi[ch] = 9'(rx_lvl[ch]) >= {1'b0, wmr[7:0]};
      tx_lo[ch] = 9'(tx_lvl[ch]) <= {1'b0, wmr[15:8]};
      sr[ch] = (rx_lvl[ch] != '0);
      sr[8+ch] = rx_hi[ch];
      sr[16+ch] = tx_lo[ch];
      sr[24+ch] = !tx_full[ch];
      cr_mask[ch] = 1'b1;
      cr_mask[8+ch] = 1'b1;
      stkr_mask[ch] = 1'b1;
      stkr_mask[8+ch] = 1'b1;
      stkr_set[ch] = rx_ovf_set[ch];
      stkr_set[8+ch] = tx_unf_set[ch];
    end
  end

  assign wr_err = wr_en && ((wr_addr <= 5'd1) ||
                            ((wr_addr >= 5'd5) && (wr_addr <= 5'd15)) ||
                            (wr_addr >= ADDR_END) || (|tx_drop));

  always_comb begin
    rd_mux = '0;
    case (rd_addr)
      5'd0: rd_mux = ID_VAL;
      5'd1: rd_mux = sr;
      5'd2: rd_mux = cr;
      5'd3: rd_mux = {16'h0, wmr};
      5'd4: rd_mux = stkr;
      default: begin
        for (int ch = 0; ch < NCH; ch++) begin
          if (rd_addr == 5'(16 + ch) && rx_lvl[ch] != '0)
            rd_mux = 32'($signed(rx_mem[ch][rx_rp[ch]]));
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cr <= '0;
      wmr <= {WM_RST, WM_RST};
      stkr <= '0;
      interrupt <= 1'b0;
      rd_data <= '0;
      rd_valid_out <= 1'b0;
      for (int ch = 0; ch < NCH; ch++) begin
        rx_wp[ch] <= '0; rx_rp[ch] <= '0; rx_lvl[ch] <= '0;
        tx_wp[ch] <= '0; tx_rp[ch] <= '0; tx_lvl[ch] <= '0;
        aud_out_q[ch] <= '0;
      end
    end else begin
      if (wr_cr) cr <= wr_data & cr_mask;
      if (wr_en && wr_addr == 5'd3) wmr <= wr_data[15:0];
      // hardware set is OR-ed in after the clear so it wins a same-cycle W1C
      stkr <= (stkr & ~stkr_clr) | stkr_set;
      interrupt <= (cr[16] && |rx_hi) || (cr[17] && |tx_lo) || (cr[18] && |stkr);
      rd_valid_out <= rd_valid_in;
      if (rd_valid_in) rd_data <= rd_mux;
      for (int ch = 0; ch < NCH; ch++) begin
        if (rx_push[ch]) rx_wp[ch] <= rx_wp[ch] + 1'b1;
        if (rx_pop[ch]) rx_rp[ch] <= rx_rp[ch] + 1'b1;
        rx_lvl[ch] <= rx_lvl[ch] + LW'(rx_push[ch]) - LW'(rx_pop[ch]);
        if (tx_push[ch]) tx_wp[ch] <= tx_wp[ch] + 1'b1;
        if (tx_pop[ch]) tx_rp[ch] <= tx_rp[ch] + 1'b1;
        tx_lvl[ch] <= tx_lvl[ch] + LW'(tx_push[ch]) - LW'(tx_pop[ch]);
        if (tx_req[ch]) aud_out_q[ch] <= tx_pop[ch] ? tx_mem[ch][tx_rp[ch]] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int ch = 0; ch < NCH; ch++) begin
      if (rx_push[ch]) rx_mem[ch][rx_wp[ch]] <= aud_in[ch*SW +: SW];
      if (tx_push[ch]) tx_mem[ch][tx_wp[ch]] <= wr_data[SW-1:0];
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign aud_out[g*SW +: SW] = aud_out_q[g];
  end
endmodule

// File: tb/tb_cbi980_audio_buf.sv
// Directed bench for cbi980_audio_buf at default parameters: a vector table for the
// register/FIFO basics plus hand sequences for overflow, full-TX and soft-reset corners.
module tb_cbi980_audio_buf;
  localparam int NCH = 2;
  localparam int DL = 4;
  localparam int SW = 24;

  logic clk = 1'b0;
  logic rst;
  logic interrupt;
  logic [4:0] wr_addr;
  logic [31:0] wr_data;
  logic wr_en;
  logic wr_err;
  logic [4:0] rd_addr;
  logic [31:0] rd_data;
  logic rd_valid_in;
  logic rd_valid_out;
  logic [NCH-1:0] aud_in_vld;
  logic [NCH*SW-1:0] aud_in;
  logic [NCH-1:0] aud_out_req;
  logic [NCH*SW-1:0] aud_out;

  cbi980_audio_buf #(.NCH(NCH), .DEPTH_LOG2(DL), .SW(SW)) dut (
    .clk(clk), .rst(rst), .interrupt(interrupt),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .wr_err(wr_err),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid_in(rd_valid_in), .rd_valid_out(rd_valid_out),
    .aud_in_vld(aud_in_vld), .aud_in(aud_in), .aud_out_req(aud_out_req), .aud_out(aud_out)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nbad = 0;

  typedef enum int {OP_RD, OP_WR, OP_PUSH, OP_REQ} op_t;
  typedef struct {
    op_t         op;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input op_t op, input logic [4:0] a, input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.op = op; v.addr = a; v.data = d; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wr(input logic [4:0] a, input logic [31:0] d, input logic exp_err, input string nm);
    wr_addr = a; wr_data = d; wr_en = 1'b1;
    #1;
    check({nm, ".wr_err"}, {31'b0, wr_err}, {31'b0, exp_err});
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_rd(input logic [4:0] a, input logic [31:0] exp, input string nm);
    rd_addr = a; rd_valid_in = 1'b1;
    tick();
    rd_valid_in = 1'b0;
    check({nm, ".rd_valid"}, {31'b0, rd_valid_out}, 32'd1);
    check({nm, ".rd_data"}, rd_data, exp);
  endtask

  task automatic do_push(input int ch, input logic [SW-1:0] d);
    aud_in_vld[ch] = 1'b1;
    aud_in[ch*SW +: SW] = d;
    tick();
    aud_in_vld = '0;
  endtask

  task automatic do_req(input int ch, input logic [SW-1:0] exp, input string nm);
    aud_out_req[ch] = 1'b1;
    tick();
    aud_out_req = '0;
    check({nm, ".aud_out"}, 32'(aud_out[ch*SW +: SW]), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_addr = '0; wr_data = '0; wr_en = 1'b0;
    rd_addr = '0; rd_valid_in = 1'b0; aud_in_vld = '0; aud_in = '0; aud_out_req = '0;

    // reset-state registers, basic RX path, TX path, watermark boundaries
    add(OP_RD, 0, 0, 32'hcb199810);
    add(OP_RD, 1, 0, 32'h0303_0000);
    add(OP_RD, 2, 0, 32'h0);
    add(OP_RD, 3, 0, 32'h0000_0808);
    add(OP_RD, 4, 0, 32'h0);
    add(OP_RD, 8, 0, 32'h0);
    add(OP_RD, 20, 0, 32'h0);
    add(OP_PUSH, 0, 32'h111111, 0);
    add(OP_REQ, 0, 0, 32'h0);
    add(OP_RD, 1, 0, 32'h0303_0000);
    add(OP_RD, 4, 0, 32'h0);
    add(OP_WR, 2, 32'h1, 0);
    add(OP_PUSH, 0, 32'h800001, 0);
    add(OP_PUSH, 0, 32'h000001, 0);
    add(OP_PUSH, 0, 32'h000002, 0);
    add(OP_RD, 1, 0, 32'h0303_0001);
    add(OP_RD, 16, 0, 32'hff80_0001);
    add(OP_RD, 16, 0, 32'h1);
    add(OP_RD, 16, 0, 32'h2);
    add(OP_RD, 16, 0, 32'h0);
    add(OP_RD, 1, 0, 32'h0303_0000);
    add(OP_WR, 2, 32'h101, 0);
    add(OP_WR, 16, 32'h0012_3456, 0);
    add(OP_WR, 16, 32'hff65_4321, 0);
    add(OP_RD, 1, 0, 32'h0303_0000);
    add(OP_REQ, 0, 0, 32'h123456);
    add(OP_REQ, 0, 0, 32'h654321);
    add(OP_REQ, 0, 0, 32'h0);
    add(OP_RD, 4, 0, 32'h0000_0100);
    add(OP_WR, 4, 32'h100, 0);
    add(OP_RD, 4, 0, 32'h0);
    add(OP_WR, 3, 32'h0102, 0);
    add(OP_PUSH, 0, 32'h7fffff, 0);
    add(OP_RD, 1, 0, 32'h0303_0001);
    add(OP_PUSH, 0, 32'h000010, 0);
    add(OP_RD, 1, 0, 32'h0303_0101);
    add(OP_WR, 16, 32'h5, 0);
    add(OP_WR, 16, 32'h6, 0);
    add(OP_RD, 1, 0, 32'h0302_0101);
    add(OP_RD, 16, 0, 32'h007f_ffff);
    add(OP_RD, 16, 0, 32'h10);
    add(OP_REQ, 0, 0, 32'h5);
    add(OP_REQ, 0, 0, 32'h6);
    add(OP_WR, 5, 32'h0, 1);
    add(OP_WR, 15, 32'h0, 1);
    add(OP_WR, 0, 32'h0, 1);
    add(OP_WR, 3, 32'h0808, 0);
    add(OP_RD, 3, 0, 32'h0000_0808);

    repeat (3) tick();
    check("reset.rd_valid", {31'b0, rd_valid_out}, 32'd0);
    check("reset.interrupt", {31'b0, interrupt}, 32'd0);
    check("reset.rd_data", rd_data, 32'd0);
    check("reset.aud_out0", 32'(aud_out[SW-1:0]), 32'd0);
    rst = 1'b0;
    tick();

    foreach (tbl[i]) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      case (tbl[i].op)
        OP_RD:   do_rd(tbl[i].addr, tbl[i].exp, nm);
        OP_WR:   do_wr(tbl[i].addr, tbl[i].data, tbl[i].exp[0], nm);
        OP_PUSH: do_push(int'(tbl[i].addr), tbl[i].data[SW-1:0]);
        default: do_req(int'(tbl[i].addr), tbl[i].exp[SW-1:0], nm);
      endcase
    end

    // rd_data holds while idle
    tick();
    check("idle.rd_valid", {31'b0, rd_valid_out}, 32'd0);
    check("idle.rd_data", rd_data, 32'h0000_0808);

    // RX overflow on channel 1 with ie_err
    do_wr(2, 32'h0004_0002, 1'b0, "ovf.cr");
    for (int i = 0; i < 16; i++) do_push(1, 24'(32'h100 + i));
    check("ovf.int_before", {31'b0, interrupt}, 32'd0);
    do_rd(1, 32'h0303_0202, "ovf.sr_full");
    do_push(1, 24'h0abcde);
    check("ovf.int_lat0", {31'b0, interrupt}, 32'd0);
    tick();
    check("ovf.int_lat1", {31'b0, interrupt}, 32'd1);
    do_rd(4, 32'h2, "ovf.stkr");
    do_rd(17, 32'h100, "ovf.head");
    do_wr(4, 32'h2, 1'b0, "ovf.w1c");
    tick();
    check("ovf.int_clear", {31'b0, interrupt}, 32'd0);

    // TX0 full, dropped write, error addresses, drain order
    do_wr(2, 32'h100, 1'b0, "txf.cr");
    for (int i = 0; i < 16; i++) do_wr(16, 32'h00a000 + i, 1'b0, $sformatf("txf.fill%0d", i));
    do_wr(16, 32'h00a010, 1'b1, "txf.over");
    do_rd(1, 32'h0202_0202, "txf.sr");
    do_wr(1, 32'h0, 1'b1, "txf.addr1");
    do_wr(18, 32'h0, 1'b1, "txf.addr18");
    do_req(0, 24'h00a000, "txf.pop0");
    do_rd(1, 32'h0302_0202, "txf.sr15");
    for (int i = 1; i < 16; i++) do_req(0, 24'(32'h00a000 + i), $sformatf("txf.pop%0d", i));
    do_req(0, 24'h0, "txf.empty");
    do_rd(4, 32'h100, "txf.unf");
    do_wr(4, 32'h100, 1'b0, "txf.w1c");

    // RX0 full with simultaneous push and pop, then soft reset
    do_wr(2, 32'h1, 1'b0, "sim.cr");
    for (int i = 0; i < 16; i++) do_push(0, 24'(32'h200 + i));
    aud_in_vld[0] = 1'b1; aud_in[SW-1:0] = 24'h000300;
    rd_addr = 5'd16; rd_valid_in = 1'b1;
    tick();
    aud_in_vld = '0; rd_valid_in = 1'b0;
    check("sim.rd_data", rd_data, 32'h200);
    do_rd(4, 32'h0, "sim.no_ovf");
    do_push(0, 24'h000301);
    do_rd(4, 32'h1, "sim.ovf_after");
    do_rd(16, 32'h201, "sim.order");
    do_wr(2, 32'h8000_0000, 1'b0, "srst.wr");
    do_rd(1, 32'h0303_0000, "srst.sr");
    do_rd(3, 32'h0000_0808, "srst.wmr");
    do_rd(2, 32'h0, "srst.cr");
    do_rd(4, 32'h0, "srst.stkr");
    do_rd(17, 32'h0, "srst.rx1");

    // reset aborts an in-flight read
    rd_addr = 5'd0; rd_valid_in = 1'b1; rst = 1'b1;
    tick();
    rd_valid_in = 1'b0; rst = 1'b0;
    check("rstabort.rd_valid", {31'b0, rd_valid_out}, 32'd0);
    check("rstabort.rd_data", rd_data, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
